systolic_pq_cell: RTL and testbench
===================================

SYSTOLIC_PQ_CELL -- requirements
Module: systolic_pq_cell

Interface
REQ-001 SHALL have parameter KW, default 8, key width in bits.
REQ-002 SHALL have parameter VW, default 4, value (payload) width in bits; entry width W = KW+VW, key = entry[W-1:VW].
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port en  input  1  active-phase enable; driven from the even or odd phase by cell-index parity.
REQ-006 SHALL have port ai  input  W  left request word; PQINF = extract request, anything else = no request.
REQ-007 SHALL have port bi  input  W  left insert word moving right; PQINF = bubble.
REQ-008 SHALL have port ri  input  W  entry returned from the right cell; the last cell ties it to PQINF.
REQ-009 SHALL have ports ao, bo  output  W each  registered request and insert words to the right cell.
REQ-010 SHALL have port lo  output  W  registered entry returned to the left cell.
REQ-011 SHALL have port occ  output  1  high when the resident entry is not PQINF.

Function
REQ-012 SHALL define PQINF as all ones and PQNEGINF as all zeros of width W.
REQ-013 SHALL hold one resident entry a_q and a two-state FSM: IDLE (a_q is valid or empty) and FILL (a_q is a hole awaiting ri).
REQ-014 SHALL compare on key bits only; on equal keys the resident entry wins, so the incoming entry moves right and equal keys leave in FIFO order.
REQ-015 SHALL leave all registers, state and outputs unchanged in any cycle with en low.
REQ-016 On en in IDLE with ai != PQINF: a_q <= min(a_q,bi); bo <= max(a_q,bi); ao <= PQNEGINF; lo <= PQINF; stay IDLE.
REQ-017 On en in IDLE with ai == PQINF: lo <= a_q; a_q <= PQINF; bo <= PQINF; ao <= PQINF; go to FILL.
REQ-018 On en in FILL with ai != PQINF: a_q <= min(ri,bi); bo <= max(ri,bi); ao <= PQNEGINF; lo <= PQINF; go to IDLE.
REQ-019 On en in FILL with ai == PQINF: lo <= min(ri,bi); a_q stays PQINF; bo <= max(ri,bi); ao <= PQINF; stay FILL.
REQ-020 SHALL produce all outputs from registers with one en-cycle latency; no combinational path from inputs to outputs.
REQ-021 SHALL treat an empty cell (a_q = PQINF) as valid: an extract returns lo = PQINF; an insert of bi = PQINF leaves the cell empty.
REQ-022 occ SHALL be computed combinationally from a_q as (a_q != PQINF).

Reset
REQ-023 On rst high at a clock edge, regardless of en: a_q = PQINF, bo = PQINF, ao = PQNEGINF, lo = PQINF, state IDLE, occ = 0.
REQ-024 Reset SHALL override any in-progress FILL and discard the pending hole without emitting lo.

Structure
REQ-025 Package systolic_pq_pkg SHALL hold the FSM state enum and the PQINF/PQNEGINF definitions, expressed as W-wide all-ones and all-zeros.
REQ-026 SHALL use one combinational sub-module, systolic_pq_cmpswap (inputs x and y; outputs mn and mx; key-only compare; ties return x as mn), instantiated once with x taken from a_q in IDLE or ri in FILL and y = bi.
REQ-027 Chaining rule: cell k ai/bi connect to cell k-1 ao/bo, and cell k ri connects to cell k+1 lo; adjacent cells use opposite en phases.

Verification (KW=8, VW=4, hex entries)
REQ-028 Reset, then en with bi=0x301 and ai=0x000 -> a_q=0x301, bo=0xFFF, ao=0x000, lo=0xFFF, occ=1.
REQ-029 Resident 0x301, en with bi=0x205 -> a_q=0x205, bo=0x301; repeat with en low -> all outputs held.
REQ-030 Tie: resident 0x301, bi=0x30A -> a_q=0x301, bo=0x30A.
REQ-031 Resident 0x205, en with ai=0xFFF -> lo=0x205, ao=0xFFF, a_q=0xFFF, FILL; next en with ri=0x301, bi=0xFFF, ai=0x000 -> a_q=0x301, lo=0xFFF, IDLE.
REQ-032 FILL, en with ri=0x400, bi=0x150, ai=0x000 -> a_q=0x150, bo=0x400, IDLE; in another FILL, en with ai=0xFFF, ri=0x400, bi=0xFFF -> lo=0x400, bo=0xFFF, stay FILL.
REQ-033 rst asserted in FILL -> next cycle IDLE, a_q=0xFFF, lo=0xFFF, ao=0x000, occ=0.

Source files
------------

// File: rtl/systolic_pq_pkg.sv
// Shared definitions for the systolic priority-queue cell: FSM states and sentinel entries.
package systolic_pq_pkg;

    typedef enum logic {
        StIdle,
        StFill
    } pq_state_e;

    // Widest entry supported; cells take the low W bits of these sentinels.
    localparam int unsigned PQ_MAX_W = 64;
    localparam logic [PQ_MAX_W-1:0] PQ_INF_MAX    = {PQ_MAX_W{1'b1}};
    localparam logic [PQ_MAX_W-1:0] PQ_NEGINF_MAX = {PQ_MAX_W{1'b0}};

endpackage

// File: rtl/systolic_pq_cmpswap.sv
// Key-only compare-and-swap; on equal keys x is returned as the minimum.
module systolic_pq_cmpswap #(
    parameter int unsigned KW = 8,
    parameter int unsigned VW = 4
) (
    input  logic [KW+VW-1:0] x,
    input  logic [KW+VW-1:0] y,
    output logic [KW+VW-1:0] mn,
    output logic [KW+VW-1:0] mx
);

    logic y_less;

    assign y_less = (y[KW+VW-1:VW] < x[KW+VW-1:VW]);
    assign mn     = y_less ? y : x;
    assign mx     = y_less ? x : y;

endmodule

// File: rtl/systolic_pq_cell.sv
// One cell of a systolic priority queue: holds a single entry, passes larger inserts right
// and refills its slot from the right neighbour after an extract.
module systolic_pq_cell
    import systolic_pq_pkg::*;
#(
    parameter int unsigned KW = 8,
    parameter int unsigned VW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [KW+VW-1:0] ai,
    input  logic [KW+VW-1:0] bi,
    input  logic [KW+VW-1:0] ri,
    output logic [KW+VW-1:0] ao,
    output logic [KW+VW-1:0] bo,
    output logic [KW+VW-1:0] lo,
    output logic             occ
);

    localparam int unsigned W = KW + VW;
    localparam logic [W-1:0] PQINF    = PQ_INF_MAX[W-1:0];
    localparam logic [W-1:0] PQNEGINF = PQ_NEGINF_MAX[W-1:0];

    pq_state_e    state_q, state_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] ao_q, ao_d;
    logic [W-1:0] bo_q, bo_d;
    logic [W-1:0] lo_q, lo_d;
    logic [W-1:0] cmp_x, cmp_mn, cmp_mx;
    logic         extract;

    // In FILL the resident slot is a hole, so the right neighbour's entry competes instead.
    assign cmp_x   = (state_q == StFill) ? ri : a_q;
    assign extract = (ai == PQINF);

    systolic_pq_cmpswap #(
        .KW(KW),
        .VW(VW)
    ) u_cmpswap (
        .x (cmp_x),
        .y (bi),
        .mn(cmp_mn),
        .mx(cmp_mx)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        ao_d    = ao_q;
        bo_d    = bo_q;
        lo_d    = lo_q;
        if (en) begin
            unique case (state_q)
                StIdle: begin
                    if (extract) begin
                        lo_d    = a_q;
                        a_d     = PQINF;
                        bo_d    = PQINF;
                        ao_d    = PQINF;
                        state_d = StFill;
                    end else begin
                        a_d  = cmp_mn;
                        bo_d = cmp_mx;
                        ao_d = PQNEGINF;
                        lo_d = PQINF;
                    end
                end
                StFill: begin
                    if (extract) begin
                        lo_d = cmp_mn;
                        a_d  = PQINF;
                        bo_d = cmp_mx;
                        ao_d = PQINF;
                    end else begin
                        a_d     = cmp_mn;
                        bo_d    = cmp_mx;
                        ao_d    = PQNEGINF;
                        lo_d    = PQINF;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= PQINF;
            ao_q    <= PQNEGINF;
            bo_q    <= PQINF;
            lo_q    <= PQINF;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            ao_q    <= ao_d;
            bo_q    <= bo_d;
            lo_q    <= lo_d;
        end
    end

    assign ao  = ao_q;
    assign bo  = bo_q;
    assign lo  = lo_q;
    assign occ = (a_q != PQINF);

endmodule

// File: tb/tb_systolic_pq_cell.sv
// Directed vector bench for systolic_pq_cell with KW=8, VW=4.
module tb_systolic_pq_cell;
    import systolic_pq_pkg::*;

    localparam int unsigned KW = 8;
    localparam int unsigned VW = 4;
    localparam int unsigned W  = KW + VW;

    logic         clk = 1'b0;
    logic         rst, en;
    logic [W-1:0] ai, bi, ri;
    logic [W-1:0] ao, bo, lo;
    logic         occ;

    int errors = 0;
    int checks = 0;

    systolic_pq_cell #(
        .KW(KW),
        .VW(VW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en (en),
        .ai (ai),
        .bi (bi),
        .ri (ri),
        .ao (ao),
        .bo (bo),
        .lo (lo),
        .occ(occ)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         en;
        logic [W-1:0] ai;
        logic [W-1:0] bi;
        logic [W-1:0] ri;
        logic [W-1:0] exp_a;
        logic [W-1:0] exp_bo;
        logic [W-1:0] exp_ao;
        logic [W-1:0] exp_lo;
        logic         exp_occ;
        logic         exp_fill;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] rr);
        @(negedge clk);
        rst = r;
        en  = e;
        ai  = a;
        bi  = b;
        ri  = rr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input vec_t v);
        chk({tag, " a_q"}, dut.a_q, v.exp_a);
        chk({tag, " bo"}, bo, v.exp_bo);
        chk({tag, " ao"}, ao, v.exp_ao);
        chk({tag, " lo"}, lo, v.exp_lo);
        chk({tag, " occ"}, {{(W-1){1'b0}}, occ}, {{(W-1){1'b0}}, v.exp_occ});
        chk({tag, " fill"}, {{(W-1){1'b0}}, dut.state_q == StFill},
            {{(W-1){1'b0}}, v.exp_fill});
    endtask

    task automatic add(input logic r, input logic e, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] rr,
                       input logic [W-1:0] xa, input logic [W-1:0] xbo,
                       input logic [W-1:0] xao, input logic [W-1:0] xlo,
                       input logic xocc, input logic xfill);
        vec_t v;
        v = '{r, e, a, b, rr, xa, xbo, xao, xlo, xocc, xfill};
        vecs.push_back(v);
    endtask

    initial begin
        vec_t v;
        rst = 1'b1;
        en  = 1'b0;
        ai  = '0;
        bi  = '1;
        ri  = '1;

        //   rst en  ai      bi      ri      a_q     bo      ao      lo      occ  fill
        add(1, 0, 12'h000, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'h000, 12'hFFF, 0, 0);
        add(0, 1, 12'h000, 12'h301, 12'hFFF, 12'h301, 12'hFFF, 12'h000, 12'hFFF, 1, 0);
        add(0, 1, 12'h000, 12'h30A, 12'hFFF, 12'h301, 12'h30A, 12'h000, 12'hFFF, 1, 0);
        add(0, 1, 12'h5A5, 12'h205, 12'hFFF, 12'h205, 12'h301, 12'h000, 12'hFFF, 1, 0);
        add(0, 0, 12'hFFF, 12'h123, 12'h777, 12'h205, 12'h301, 12'h000, 12'hFFF, 1, 0);
        add(0, 1, 12'hFFF, 12'hFFF, 12'h777, 12'hFFF, 12'hFFF, 12'hFFF, 12'h205, 0, 1);
        add(0, 1, 12'h000, 12'hFFF, 12'h301, 12'h301, 12'hFFF, 12'h000, 12'hFFF, 1, 0);
        add(0, 1, 12'hFFF, 12'hFFF, 12'h999, 12'hFFF, 12'hFFF, 12'hFFF, 12'h301, 0, 1);
        add(0, 1, 12'h000, 12'h150, 12'h400, 12'h150, 12'h400, 12'h000, 12'hFFF, 1, 0);
        add(0, 1, 12'hFFF, 12'hFFF, 12'h888, 12'hFFF, 12'hFFF, 12'hFFF, 12'h150, 0, 1);
        add(0, 1, 12'hFFF, 12'hFFF, 12'h400, 12'hFFF, 12'hFFF, 12'hFFF, 12'h400, 0, 1);
        add(0, 0, 12'h000, 12'h111, 12'h222, 12'hFFF, 12'hFFF, 12'hFFF, 12'h400, 0, 1);
        add(0, 1, 12'hFFF, 12'h240, 12'h250, 12'hFFF, 12'h250, 12'hFFF, 12'h240, 0, 1);
        add(0, 1, 12'hFFF, 12'h25C, 12'h250, 12'hFFF, 12'h25C, 12'hFFF, 12'h250, 0, 1);
        add(1, 1, 12'h000, 12'h100, 12'h200, 12'hFFF, 12'hFFF, 12'h000, 12'hFFF, 0, 0);
        add(0, 1, 12'hFFF, 12'h100, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 0, 1);
        add(0, 1, 12'h000, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'h000, 12'hFFF, 0, 0);
        add(0, 1, 12'h123, 12'hFFF, 12'h456, 12'hFFF, 12'hFFF, 12'h000, 12'hFFF, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            step(v.rst, v.en, v.ai, v.bi, v.ri);
            check_all($sformatf("vec%0d", i), v);
        end

        // Reset with en low while a hole is pending must drop it without emitting lo.
        step(0, 1, 12'h000, 12'h3AA, 12'hFFF);
        step(0, 1, 12'hFFF, 12'hFFF, 12'hFFF);
        chk("rstfill pre lo", lo, 12'h3AA);
        step(1, 0, 12'hFFF, 12'h0AB, 12'h0CD);
        v = '{1'b1, 1'b0, 12'hFFF, 12'h0AB, 12'h0CD,
              12'hFFF, 12'hFFF, 12'h000, 12'hFFF, 1'b0, 1'b0};
        check_all("rstfill", v);

        // Equal keys must leave in arrival order: 0x501 then 0x502 pass through a resident 0x500.
        step(0, 1, 12'h000, 12'h500, 12'hFFF);
        step(0, 1, 12'h000, 12'h501, 12'hFFF);
        chk("fifo1 bo", bo, 12'h501);
        step(0, 1, 12'h000, 12'h502, 12'hFFF);
        chk("fifo2 bo", bo, 12'h502);
        chk("fifo2 a_q", dut.a_q, 12'h500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule
